// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: constants and types shared by the memory-mapped UART transmitter.
//   - register offsets (mem_addr[3:2])
//   - STATUS bit positions
//   - serializer state encoding
//   - smallest legal DIVISOR value and its clamp helper
package mmio_uart_pkg;

   localparam logic [1:0] OFF_TXDATA  = 2'd0;
   localparam logic [1:0] OFF_STATUS  = 2'd1;
   localparam logic [1:0] OFF_DIVISOR = 2'd2;
   localparam logic [1:0] OFF_RSVD    = 2'd3;

   localparam int ST_FULL      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_BUSY      = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_COUNT_LSB = 8;

   localparam logic [15:0] DIV_MIN = 16'd2;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   // A bit time shorter than two clocks cannot be timed, so small values are raised.
   function automatic logic [15:0] clamp_div(input logic [15:0] d);
      return (d < DIV_MIN) ? DIV_MIN : d;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO, 2**AW entries deep.
//   clk, nrst   clock, synchronous active-low reset (contents discarded)
//   push, din   write request and data; ignored while full
//   pop, dout   read request and head-of-queue data (dout valid while !empty)
//   full, empty occupancy flags
//   count       number of stored entries (0 .. 2**AW)
// The full test uses the count before a same-cycle pop, so a pop never makes
// room for a push in the same cycle.
module uart_tx_fifo
   import mmio_uart_pkg::*;
#(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          push,
   input  logic [7:0]    din,
   input  logic          pop,
   output logic [7:0]    dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0]   DEPTH_C   = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]   ZERO_C    = {(AW+1){1'b0}};
   localparam logic [AW:0]   CNT_ONE_C = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE_C = {{(AW-1){1'b0}}, 1'b1};

   logic [7:0]    mem_r [0:(1<<AW)-1];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign push_ok_s = push && (count_r != DEPTH_C);
   assign pop_ok_s  = pop && (count_r != ZERO_C);

   // Storage array; no reset needed because occupancy is tracked by count_r.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= ZERO_C;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_ONE_C;
            2'b01:   count_r <= count_r - CNT_ONE_C;
            default: count_r <= count_r;
         endcase
      end
   end

   assign dout  = mem_r[rd_ptr_r];
   assign full  = (count_r == DEPTH_C);
   assign empty = (count_r == ZERO_C);
   assign count = count_r;

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: UART transmitter responding on the picorv32 native memory bus.
//   clk, nrst        clock, synchronous active-low reset
//   mem_valid        request valid
//   mem_addr         byte address; block decoded on mem_addr[31:4]
//   mem_wdata        write data
//   mem_wstrb        byte strobes, all zero for a read
//   mem_ready        one-cycle acknowledge, 0 when not selected
//   mem_rdata        read data while mem_ready=1, 0 otherwise
//   txd              8N1 serial output, idle high
// Registers (mem_addr[3:2]): 0 TXDATA (W), 1 STATUS (R, read clears overflow),
// 2 DIVISOR (R/W, clocks per bit), 3 reserved.
// Build option UART_TX_STALL_ON_FULL_EN: a TXDATA write to a full FIFO is held
// off until space frees up instead of being dropped with the overflow flag.
module mmio_uart_tx
   import mmio_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter logic [15:0] CLK_DIV   = 16'd104,
   parameter int          FIFO_AW   = 4
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        txd
);

   // Bus side
   logic        sel_s;
   logic        is_wr_s;
   logic [1:0]  off_s;
   logic        stall_s;
   logic        resp_s;
   logic [31:0] rdata_s;
   logic [15:0] div_wr_s;
   logic        mem_ready_r;
   logic [31:0] mem_rdata_r;
   logic        push_pend_r;
   logic [7:0]  push_data_r;
   logic [15:0] div_r;
   logic        ovf_r;

   // FIFO
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic [FIFO_AW:0] fifo_count_s;
   logic [7:0]       fifo_dout_s;
   logic             pop_s;

   // Serializer
   tx_state_e   state_r;
   tx_state_e   state_n;
   logic [15:0] timer_r;
   logic [15:0] timer_n;
   logic [2:0]  bit_cnt_r;
   logic [2:0]  bit_cnt_n;
   logic [7:0]  shift_r;
   logic [7:0]  shift_n;
   logic        txd_r;
   logic        txd_n;

   logic unused_s;
   assign unused_s = ^{mem_addr[1:0], mem_wdata[31:16]};

   assign sel_s   = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign is_wr_s = |mem_wstrb;
   assign off_s   = mem_addr[3:2];

`ifdef UART_TX_STALL_ON_FULL_EN
   assign stall_s = sel_s && is_wr_s && (off_s == OFF_TXDATA) && mem_wstrb[0] && fifo_full_s;
`else
   assign stall_s = 1'b0;
`endif

   // Respond once per request: a request still held while ready is high is the same one.
   assign resp_s = sel_s && !mem_ready_r && !stall_s;

   // Read mux for the addressed register.
   always_comb begin
      rdata_s = 32'd0;
      case (off_s)
         OFF_STATUS: begin
            rdata_s[ST_FULL]  = fifo_full_s;
            rdata_s[ST_EMPTY] = fifo_empty_s;
            rdata_s[ST_BUSY]  = (state_r != TX_IDLE);
            rdata_s[ST_OVF]   = ovf_r;
            rdata_s[ST_COUNT_LSB +: FIFO_AW+1] = fifo_count_s;
         end
         OFF_DIVISOR: rdata_s = {16'd0, div_r};
         default:     rdata_s = 32'd0;
      endcase
   end

   // DIVISOR write data merged byte-wise with the current value.
   always_comb begin
      div_wr_s = div_r;
      if (mem_wstrb[0]) begin
         div_wr_s[7:0] = mem_wdata[7:0];
      end else begin
         div_wr_s[7:0] = div_r[7:0];
      end
      if (mem_wstrb[1]) begin
         div_wr_s[15:8] = mem_wdata[15:8];
      end else begin
         div_wr_s[15:8] = div_r[15:8];
      end
   end

   // Bus response and deferred TXDATA push (the byte enters the FIFO in the ack cycle).
   always_ff @(posedge clk) begin
      if (!nrst) begin
         mem_ready_r <= 1'b0;
         mem_rdata_r <= 32'd0;
         push_pend_r <= 1'b0;
         push_data_r <= 8'd0;
      end else begin
         mem_ready_r <= resp_s;
         mem_rdata_r <= (resp_s && !is_wr_s) ? rdata_s : 32'd0;
         push_pend_r <= resp_s && is_wr_s && (off_s == OFF_TXDATA) && mem_wstrb[0];
         if (resp_s) begin
            push_data_r <= mem_wdata[7:0];
         end
      end
   end

   // DIVISOR register.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         div_r <= CLK_DIV;
      end else if (resp_s && is_wr_s && (off_s == OFF_DIVISOR) && (|mem_wstrb[1:0])) begin
         div_r <= clamp_div(div_wr_s);
      end
   end

   // Sticky overflow: set by a dropped byte, cleared by a STATUS read.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         ovf_r <= 1'b0;
      end else if (push_pend_r && fifo_full_s) begin
         ovf_r <= 1'b1;
      end else if (resp_s && !is_wr_s && (off_s == OFF_STATUS)) begin
         ovf_r <= 1'b0;
      end
   end

   uart_tx_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk   (clk),
      .nrst  (nrst),
      .push  (push_pend_r),
      .din   (push_data_r),
      .pop   (pop_s),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   // Serializer state register; txd is registered from the next state.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_r   <= TX_IDLE;
         timer_r   <= 16'd0;
         bit_cnt_r <= 3'd0;
         shift_r   <= 8'd0;
         txd_r     <= 1'b1;
      end else begin
         state_r   <= state_n;
         timer_r   <= timer_n;
         bit_cnt_r <= bit_cnt_n;
         shift_r   <= shift_n;
         txd_r     <= txd_n;
      end
   end

   // Serializer next state. Each bit lasts timer+1 cycles; the timer reloads from
   // the live DIVISOR at every bit boundary.
   always_comb begin
      state_n   = state_r;
      timer_n   = timer_r;
      bit_cnt_n = bit_cnt_r;
      shift_n   = shift_r;
      pop_s     = 1'b0;
      txd_n     = 1'b1;
      case (state_r)
         TX_IDLE: begin
            if (!fifo_empty_s) begin
               pop_s   = 1'b1;
               shift_n = fifo_dout_s;
               timer_n = div_r - 16'd1;
               state_n = TX_START;
            end else begin
               state_n = TX_IDLE;
            end
         end
         TX_START: begin
            if (timer_r == 16'd0) begin
               timer_n   = div_r - 16'd1;
               bit_cnt_n = 3'd0;
               state_n   = TX_DATA;
            end else begin
               timer_n = timer_r - 16'd1;
            end
         end
         TX_DATA: begin
            if (timer_r == 16'd0) begin
               timer_n = div_r - 16'd1;
               if (bit_cnt_r == 3'd7) begin
                  state_n = TX_STOP;
               end else begin
                  bit_cnt_n = bit_cnt_r + 3'd1;
                  shift_n   = {1'b0, shift_r[7:1]};
               end
            end else begin
               timer_n = timer_r - 16'd1;
            end
         end
         TX_STOP: begin
            if (timer_r == 16'd0) begin
               // Chain straight into the next start bit so frames have no gap.
               if (!fifo_empty_s) begin
                  pop_s   = 1'b1;
                  shift_n = fifo_dout_s;
                  timer_n = div_r - 16'd1;
                  state_n = TX_START;
               end else begin
                  state_n = TX_IDLE;
               end
            end else begin
               timer_n = timer_r - 16'd1;
            end
         end
         default: begin
            state_n = TX_IDLE;
         end
      endcase
      case (state_n)
         TX_START: txd_n = 1'b0;
         TX_DATA:  txd_n = shift_n[0];
         default:  txd_n = 1'b1;
      endcase
   end

   assign mem_ready = mem_ready_r;
   assign mem_rdata = mem_rdata_r;
   assign txd       = txd_r;

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'h0200_0000;

   logic        clk = 1'b0;
   logic        nrst;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        txd;

   mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(16'd104), .FIFO_AW(4)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .txd       (txd)
   );

   always #5 clk = ~clk;

   int  cyc = 0;
   bit  trace [0:19999];
   logic txd_prev = 1'b1;
   int  fall_q[$];
   int  total = 0;
   int  bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // txd trace indexed by cycle number, plus falling-edge timestamps
   always @(negedge clk) begin
      if (cyc < 20000) trace[cyc] <= txd;
      txd_prev <= txd;
      if (txd_prev === 1'b1 && txd === 1'b0) fall_q.push_back(cyc);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  off;
      logic [3:0]  ws;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_true(input string name, input bit cond);
      total++;
      if (!cond) begin
         bad++;
         $display("FAIL %s: condition false, want true", name);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) tick();
   endtask

   // One bus transaction; lat = cycles from drive to ready, -1 on timeout.
   task automatic bus(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] rd, output int lat);
      mem_valid = 1'b1; mem_addr = addr; mem_wdata = wd; mem_wstrb = ws;
      lat = 0; rd = 32'd0;
      do begin
         tick();
         lat++;
      end while (!mem_ready && lat < 500);
      if (!mem_ready) lat = -1;
      else rd = mem_rdata;
      mem_valid = 1'b0; mem_wstrb = 4'd0;
      tick();
   endtask

   task automatic wr(input logic [1:0] off, input logic [31:0] d);
      logic [31:0] rd;
      int lat;
      bus({BASE[31:4], off, 2'b00}, d, 4'hF, rd, lat);
      check32("wr_ack", lat, 1);
   endtask

   task automatic rdreg(input logic [1:0] off, output logic [31:0] v);
      int lat;
      bus({BASE[31:4], off, 2'b00}, 32'd0, 4'h0, v, lat);
      check32("rd_ack", lat, 1);
   endtask

   task automatic wait_fall(output int s);
      int lim;
      lim = cyc + 1000;
      while (fall_q.size() == 0 && cyc < lim) tick();
      check_true("start_seen", fall_q.size() != 0);
      s = (fall_q.size() != 0) ? fall_q[0] : 0;
   endtask

   // Frame check from the trace: start bit lasts d0 cycles, every later bit d cycles.
   task automatic check_frame(input string name, input int s, input logic [7:0] data,
                              input int d0, input int d);
      int len, errs, idx;
      logic e;
      len = d0 + 9 * d;
      wait_cyc(s + len + 1);
      errs = 0;
      for (int k = 0; k < len; k++) begin
         idx = (k < d0) ? 0 : 1 + (k - d0) / d;
         if (idx == 0) e = 1'b0;
         else if (idx == 9) e = 1'b1;
         else e = data[idx-1];
         if (trace[s+k] !== e) errs++;
      end
      check32(name, errs, 0);
   endtask

   initial begin
      vec_t        vecs [20];
      logic [31:0] v;
      int          lat, s, c0, pulses, errs;
      bit          first_ok;

      vecs[0]  = '{2'd1, 4'h0, 32'h0,        32'h0000_0002};
      vecs[1]  = '{2'd2, 4'h0, 32'h0,        32'd104};
      vecs[2]  = '{2'd0, 4'h0, 32'h0,        32'h0};
      vecs[3]  = '{2'd3, 4'h0, 32'h0,        32'h0};
      vecs[4]  = '{2'd3, 4'hF, 32'hFFFF_FFFF, 32'h0};
      vecs[5]  = '{2'd3, 4'h0, 32'h0,        32'h0};
      vecs[6]  = '{2'd1, 4'hF, 32'hFFFF_FFFF, 32'h0};
      vecs[7]  = '{2'd1, 4'h0, 32'h0,        32'h0000_0002};
      vecs[8]  = '{2'd2, 4'hF, 32'h0,        32'h0};
      vecs[9]  = '{2'd2, 4'h0, 32'h0,        32'd2};
      vecs[10] = '{2'd2, 4'hF, 32'h1,        32'h0};
      vecs[11] = '{2'd2, 4'h0, 32'h0,        32'd2};
      vecs[12] = '{2'd2, 4'hF, 32'h1234,     32'h0};
      vecs[13] = '{2'd2, 4'h0, 32'h0,        32'h1234};
      vecs[14] = '{2'd2, 4'h1, 32'h77,       32'h0};
      vecs[15] = '{2'd2, 4'h0, 32'h0,        32'h1277};
      vecs[16] = '{2'd0, 4'h2, 32'h12,       32'h0};
      vecs[17] = '{2'd1, 4'h0, 32'h0,        32'h0000_0002};
      vecs[18] = '{2'd2, 4'hF, 32'h4,        32'h0};
      vecs[19] = '{2'd2, 4'h0, 32'h0,        32'd4};

      nrst = 1'b0; mem_valid = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'd0;
      repeat (3) tick();
      check32("rst_ready", {31'd0, mem_ready}, 32'd0);
      check32("rst_rdata", mem_rdata, 32'd0);
      check32("rst_txd", {31'd0, txd}, 32'd1);
      nrst = 1'b1;
      tick();

      // register vectors
      for (int i = 0; i < 20; i++) begin
         bus({BASE[31:4], vecs[i].off, 2'b00}, vecs[i].wd, vecs[i].ws, v, lat);
         check32($sformatf("vec%0d_ack", i), lat, 1);
         if (vecs[i].ws == 4'h0) check32($sformatf("vec%0d_rd", i), v, vecs[i].exp);
      end

      // valid held for two cycles: exactly one ack, in the cycle after selection
      mem_valid = 1'b1; mem_addr = BASE + 32'h8; mem_wstrb = 4'h0;
      pulses = 0; first_ok = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) mem_valid = 1'b0;
         tick();
         if (mem_ready) begin
            pulses++;
            if (k == 0) first_ok = 1'b1;
         end
      end
      check32("one_ack", pulses, 1);
      check_true("ack_n1", first_ok);

      // single frame 0x55
      fall_q.delete();
      c0 = cyc;
      wr(2'd0, 32'h55);
      wait_fall(s);
      check32("start_lat", s, c0 + 3);
      check_frame("frame55", s, 8'h55, 4, 4);
      rdreg(2'd1, v);
      check32("idle_st", v, 32'h2);

      // back-to-back frames
      fall_q.delete();
      c0 = cyc;
      wr(2'd0, 32'hA5);
      wr(2'd0, 32'h3C);
      rdreg(2'd1, v);
      check32("b2b_st", v, 32'h104);
      errs = 0;
      while (cyc < c0 + 79) begin
         rdreg(2'd1, v);
         if (!v[2]) errs++;
      end
      check32("b2b_busy", errs, 0);
      wait_fall(s);
      check32("b2b_start", s, c0 + 3);
      check_frame("frameA5", s, 8'hA5, 4, 4);
      check_frame("frame3C", s + 40, 8'h3C, 4, 4);
      rdreg(2'd1, v);
      check32("b2b_done", v, 32'h2);

      // DIVISOR change during the start bit
      fall_q.delete();
      c0 = cyc;
      wr(2'd0, 32'h55);
      tick();
      wr(2'd2, 32'd8);
      wait_fall(s);
      check32("div8_start", s, c0 + 3);
      check_frame("frame_div8", s, 8'h55, 4, 8);
      rdreg(2'd2, v);
      check32("div8_rb", v, 32'd8);

      // FIFO full behaviour
      wr(2'd2, 32'd16);
      wr(2'd0, 32'h00);
      for (int i = 0; i < 16; i++) wr(2'd0, 32'(i + 1));
      bus(BASE, 32'hEE, 4'h1, v, lat);
`ifdef UART_TX_STALL_ON_FULL_EN
      check_true("stall_lat", lat > 1);
      rdreg(2'd1, v);
      check32("full_st1", v, 32'h1005);
      rdreg(2'd1, v);
      check32("full_st2", v, 32'h1005);
`else
      check32("ovf_ack", lat, 1);
      rdreg(2'd1, v);
      check32("full_st1", v, 32'h100D);
      rdreg(2'd1, v);
      check32("full_st2", v, 32'h1005);
`endif
      nrst = 1'b0;
      tick();
      nrst = 1'b1;
      tick();
      rdreg(2'd1, v);
      check32("rst_st", v, 32'h2);
      rdreg(2'd2, v);
      check32("rst_div", v, 32'd104);
      wr(2'd2, 32'd4);

      // reset during data bit 3
      fall_q.delete();
      c0 = cyc;
      wr(2'd0, 32'h00);
      wr(2'd0, 32'h00);
      wait_fall(s);
      check32("rstmid_start", s, c0 + 3);
      wait_cyc(s + 17);
      check32("rstmid_pre", {31'd0, txd}, 32'd0);
      nrst = 1'b0;
      tick();
      check32("rstmid_txd", {31'd0, txd}, 32'd1);
      tick();
      nrst = 1'b1;
      fall_q.delete();
      tick();
      rdreg(2'd1, v);
      check32("rstmid_st", v, 32'h2);
      repeat (100) tick();
      check32("no_residual", fall_q.size(), 0);

      // out-of-range address: no response, rdata stays 0
      errs = 0;
      mem_valid = 1'b1; mem_addr = BASE + 32'h10; mem_wdata = 32'h99; mem_wstrb = 4'hF;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (mem_ready !== 1'b0 || mem_rdata !== 32'd0) errs++;
      end
      mem_addr = BASE + 32'h18;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (mem_ready !== 1'b0 || mem_rdata !== 32'd0) errs++;
      end
      mem_wstrb = 4'h0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (mem_ready !== 1'b0 || mem_rdata !== 32'd0) errs++;
      end
      mem_valid = 1'b0;
      tick();
      check32("unsel_quiet", errs, 0);
      rdreg(2'd2, v);
      check32("unsel_div", v, 32'd104);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
